core_sequencer: RTL
===================

// Module: core_sequencer
// PURPOSE
//   Multi-cycle control FSM for the RV32I core. It steps each instruction through
//   FETCH -> DECODE -> EXEC -> [MEM] -> WB and drives the imem/dmem req/ack handshakes.
//   It also gates the decode, execute, register-file and PC update enables,
//   counts retired instructions and raises traps.
//   Sits between the instruction/data memory ports and the decode/execute datapath.
// PARAMETERS
//   TIMEOUT_CYCLES  16  max cycles a memory req may stay unacknowledged (>=2)
//   CNT_W           32  width of the retired-instruction counter
// PORTS
//   clk           in   1      clock, all state updates on posedge
//   rst           in   1      reset, asynchronous, active-high
//   run           in   1      level: 1 = execute instructions, 0 = stop at instruction boundary
//   imem_req      out  1      instruction fetch request (held until ack/err/timeout)
//   imem_ack      in   1      fetch complete, instruction valid this cycle
//   imem_err      in   1      fetch bus error
//   decode_en     out  1      decoder capture enable (DECODE state)
//   instr_class   in   3      valid during DECODE: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 SYSTEM,
//                             5 FENCE, 6 JUMP, 7 ILLEGAL
//   exec_en       out  1      ALU/branch-unit enable (EXEC state)
//   dmem_req      out  1      data memory request
//   dmem_we       out  1      1 = store, 0 = load; valid while dmem_req=1
//   dmem_ack      in   1      data access complete
//   rf_we         out  1      register file write enable (WB)
//   pc_we         out  1      PC update enable (WB)
//   retire        out  1      1-cycle pulse per retired instruction
//   instret       out  CNT_W  retired-instruction count
//   trap          out  1      level: sequencer halted in TRAP
//   trap_cause    out  2      0 illegal, 1 bus error, 2 timeout, 3 ecall/ebreak
//   trap_clear    in   1      leave TRAP
//   busy          out  1      state is not IDLE and not TRAP
// BEHAVIOUR
// - Reset: state=IDLE; instret=0; trap_cause=0; timeout counter=0; every output 0.
//   rst wins over every other input and aborts any outstanding req immediately.
// - All control outputs are Moore, decoded from the registered state plus class_q.
// - IDLE: run=1 -> FETCH.
// - FETCH: imem_req=1.
//   - imem_err=1 -> TRAP, cause 1. err wins over a simultaneous ack.
//   - imem_ack=1 -> DECODE.
//   - TIMEOUT_CYCLES cycles without ack -> TRAP, cause 2. An ack in the final cycle wins.
// - DECODE (1 cycle): decode_en=1; instr_class is registered into class_q.
//   - 7 -> TRAP, cause 0.
//   - 4 -> TRAP, cause 3.
//   - otherwise -> EXEC.
// - EXEC (1 cycle): exec_en=1. LOAD/STORE -> MEM; otherwise -> WB.
// - MEM: dmem_req=1; dmem_we = (class_q==STORE).
//   - dmem_ack -> WB.
//   - Timeout (same rule as FETCH) -> TRAP, cause 2.
// - WB (1 cycle): pc_we=1; retire=1; instret += 1, wrapping modulo 2^CNT_W.
//   - rf_we=1 only for class_q in {ALU, LOAD, JUMP}.
//   - Next state: FETCH if run=1, else IDLE.
// - TRAP: trap=1; trap_cause is held. No retire and no pc_we.
//   - trap_clear=1 -> FETCH if run=1, else IDLE; trap_cause is kept until the next trap.
// - Timeout counter: cleared on every entry to FETCH or MEM; increments each cycle req is
//   high without ack; saturates, never wraps.
// - run deasserted mid-instruction: the current instruction completes through WB, then IDLE.
//   A fetch is never abandoned once imem_req is asserted.
// - Latency with zero-wait memory:
//   - ALU/BRANCH/JUMP/FENCE: 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
//   - LOAD/STORE: 5 cycles.
//   - Each wait cycle on ack adds 1.
// - Req outputs deassert in the cycle after the ack, on leaving the state.
// TESTING
// - run=1, class=ALU x3, ack same cycle -> retire every 4th cycle, rf_we=1 in each WB, instret=3.
// - class=LOAD, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, retire at cycle 8.
//   Same test with STORE -> dmem_we=1, rf_we=0.
// - Timeout: imem_ack never, TIMEOUT_CYCLES=16 -> imem_req high 16 cycles, then trap=1, cause=2.
//   Same test with ack in cycle 16 -> no trap.
// - class=7 -> trap cause 0, no retire, instret unchanged; trap_clear with run=1 -> FETCH next cycle.
//   class=4 -> cause 3. imem_err together with ack -> cause 1.
// - run dropped during MEM -> instruction retires, then IDLE, busy=0.
//   rst asserted mid-MEM -> dmem_req=0 immediately, instret=0.
//   instret at 2^CNT_W-1 plus one retire -> 0.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32I core.
// Steps each instruction FETCH -> DECODE -> EXEC -> [MEM] -> WB, runs the
// imem/dmem request handshakes, gates datapath enables, counts retired
// instructions and halts in TRAP on illegal/system instructions, bus errors
// and memory timeouts.
module core_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic             imem_err,
  output logic             decode_en,
  input  logic [2:0]       instr_class,
  output logic             exec_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause,
  input  logic             trap_clear,
  output logic             busy
);

  // Timeout counter only needs to reach TIMEOUT_CYCLES before it saturates.
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] CLS_ALU     = 3'd0;
  localparam logic [2:0] CLS_LOAD    = 3'd1;
  localparam logic [2:0] CLS_STORE   = 3'd2;
  localparam logic [2:0] CLS_SYSTEM  = 3'd4;
  localparam logic [2:0] CLS_JUMP    = 3'd6;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_BUS     = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_ECALL   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       class_reg, class_next;
  logic [1:0]       cause_reg, cause_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic [CNT_W-1:0] instret_reg, instret_next;
  logic             tmo_hit;

  // State and datapath-control registers; reset aborts any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      class_reg   <= '0;
      cause_reg   <= '0;
      tmo_reg     <= '0;
      instret_reg <= '0;
    end else begin
      state_reg   <= state_next;
      class_reg   <= class_next;
      cause_reg   <= cause_next;
      tmo_reg     <= tmo_next;
      instret_reg <= instret_next;
    end
  end

  // Next-state, cause capture, retire counting and request timeout tracking.
  always_comb begin
    state_next   = state_reg;
    class_next   = class_reg;
    cause_next   = cause_reg;
    tmo_next     = tmo_reg;
    instret_next = instret_reg;
    // Last permitted wait cycle: an ack arriving now still wins.
    tmo_hit      = (tmo_reg == TMO_LAST);
    case (state_reg)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_err) begin
          state_next = S_TRAP;
          cause_next = CAUSE_BUS;
        end else if (imem_ack) begin
          state_next = S_DECODE;
        end else if (tmo_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        class_next = instr_class;
        if (instr_class == CLS_ILLEGAL) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else if (instr_class == CLS_SYSTEM) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ECALL;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (class_reg == CLS_LOAD || class_reg == CLS_STORE) state_next = S_MEM;
        else                                                 state_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_next = S_WB;
        end else if (tmo_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        instret_next = instret_reg + 1'b1;
        state_next   = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        if (trap_clear) state_next = run ? S_FETCH : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Counter runs only while a request is pending; every other state
    // clears it, so each entry into FETCH or MEM starts from zero.
    if ((state_reg == S_FETCH && !imem_ack) || (state_reg == S_MEM && !dmem_ack)) begin
      if (tmo_reg != TMO_MAX) tmo_next = tmo_reg + 1'b1;
    end else begin
      tmo_next = '0;
    end
  end

  // Moore outputs decoded from the registered state and captured class.
  always_comb begin
    imem_req  = (state_reg == S_FETCH);
    decode_en = (state_reg == S_DECODE);
    exec_en   = (state_reg == S_EXEC);
    dmem_req  = (state_reg == S_MEM);
    dmem_we   = (state_reg == S_MEM) && (class_reg == CLS_STORE);
    pc_we     = (state_reg == S_WB);
    retire    = (state_reg == S_WB);
    rf_we     = (state_reg == S_WB) &&
                (class_reg == CLS_ALU || class_reg == CLS_LOAD || class_reg == CLS_JUMP);
    trap      = (state_reg == S_TRAP);
    busy      = (state_reg != S_IDLE) && (state_reg != S_TRAP);
  end

  assign instret    = instret_reg;
  assign trap_cause = cause_reg;

endmodule
